// File: rtl/pattern_detector_fsm_pkg.sv
// Shared types and limits for the serial pattern detector.
package pattern_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  typedef enum logic {
    ST_FILL,
    ST_ARMED
  } det_state_t;

endpackage

// File: rtl/pattern_detector_fsm_if.sv
// Serial-stream and status bundle between a bit source and the pattern detector.
interface pattern_detector_fsm_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);

  logic             x_in;
  logic             x_valid;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             clear;
  logic             y_out;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output x_in, x_valid, pattern, overlap, clear,
    input  y_out, match_count, count_sat
  );

  modport slave (
    input  x_in, x_valid, pattern, overlap, clear,
    output y_out, match_count, count_sat
  );

endinterface

// File: rtl/pattern_detector_fsm_window.sv
// Bit history and fill tracking for the pattern detector; presents the
// candidate window including the bit currently on the input.
module pattern_window #(
  parameter int PAT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             shift,    // accept x_in into the history
  input  logic             restart,  // non-overlapping match: start a fresh fill
  input  logic             flush,    // synchronous clear of history and fill
  output logic [PAT_W-1:0] win,
  output logic             armed     // history will be full after this cycle
);

  localparam int                FILL_W    = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (restart) begin
      fill_d = '0;
    end else if (shift) begin
      hist_d = {hist_q[PAT_W-2:0], x_in};
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign win   = {hist_q[PAT_W-2:0], x_in};
  assign armed = (fill_d == FILL_FULL);

endmodule

// File: rtl/pattern_detector_fsm.sv
// Mealy serial pattern detector with programmable pattern, overlap mode and a
// saturating match counter. Define REGISTERED_OUT_EN to register y_out.
module pattern_detector_fsm
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  pattern_detector_fsm_if.slave  bus
);

  det_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] win;
  logic             armed;
  logic             hit;
  logic             restart;
  logic             shift;

  assign hit     = bus.x_valid & ~bus.clear & (state_q == ST_ARMED) & (win == bus.pattern);
  assign restart = hit & ~bus.overlap;
  assign shift   = bus.x_valid & ~bus.clear & ~restart;

  pattern_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clock   (clock),
    .reset   (reset),
    .x_in    (bus.x_in),
    .shift   (shift),
    .restart (restart),
    .flush   (bus.clear),
    .win     (win),
    .armed   (armed)
  );

  // The window reports whether it will be full next cycle, which is exactly
  // the FILL/ARMED boundary including flushes and non-overlap restarts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:  if (armed)  state_d = ST_ARMED;
      ST_ARMED: if (!armed) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match_count = cnt_q;
  assign bus.count_sat   = &cnt_q;

`ifdef REGISTERED_OUT_EN
  logic y_q, y_d;

  always_comb begin
    y_d = bus.clear ? 1'b0 : hit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign bus.y_out = y_q;
`else
  assign bus.y_out = hit;
`endif

endmodule
